// File: rtl/register_file_2r1w_pkg.sv
// ============================================================================
//  Module      : register_file_2r1w_pkg
//  Description : Shared sizing helpers and the byte-merge primitive used by
//                the register file write path and both read-port bypasses.
//  Contents    : rf_be_w()       - byte lanes in a word of a given width
//                rf_depth()      - entries for a given address width
//                rf_merge_byte() - select new or old byte under one enable
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package register_file_2r1w_pkg;

   localparam int RF_BYTE_W = 8;

   // Byte lanes per word; DATA_W is checked to be a whole number of bytes
   // at elaboration of the top.
   function automatic int rf_be_w(input int data_w);
      return data_w / RF_BYTE_W;
   endfunction

   function automatic int rf_depth(input int addr_w);
      return 1 << addr_w;
   endfunction

   // One lane of the old/new merge. Words are merged by applying this lane by
   // lane, so the write path and the bypass paths cannot disagree.
   function automatic logic [RF_BYTE_W-1:0] rf_merge_byte(
      input logic [RF_BYTE_W-1:0] old_byte,
      input logic [RF_BYTE_W-1:0] new_byte,
      input logic                 en
   );
      return en ? new_byte : old_byte;
   endfunction

endpackage

`default_nettype wire

// File: rtl/register_file_2r1w_read_port.sv
// ============================================================================
//  Module      : register_file_2r1w_read_port
//  Description : One registered read port: write-first bypass against the
//                write port, clear-first and zero-register gating, and the
//                output data/valid register.
//  Ports       : clk, reset_n        - clock, async active-low reset
//                clear               - same-edge clear (read returns 0)
//                rd_en, read_addr    - read request
//                rd_word             - stored word at read_addr
//                we, write_addr,
//                byte_en, data_in    - write port, observed for bypass
//                data_out, valid     - registered read result
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_file_2r1w_read_port
   import register_file_2r1w_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 3,
   parameter int ZERO_REG = 0
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                clear,
   input  logic                rd_en,
   input  logic [ADDR_W-1:0]   read_addr,
   input  logic [DATA_W-1:0]   rd_word,
   input  logic                we,
   input  logic [ADDR_W-1:0]   write_addr,
   input  logic [DATA_W/8-1:0] byte_en,
   input  logic [DATA_W-1:0]   data_in,
   output logic [DATA_W-1:0]   data_out,
   output logic                valid
);

   localparam int BE_W = rf_be_w(DATA_W);

   logic              w_hit;
   logic              w_zero;
   logic [DATA_W-1:0] w_merged;
   logic [DATA_W-1:0] w_next;

   always_comb begin
      w_hit    = we && (write_addr == read_addr);
      w_merged = rd_word;
      for (int i = 0; i < BE_W; i++) begin
         w_merged[8*i +: 8] = rf_merge_byte(rd_word[8*i +: 8], data_in[8*i +: 8],
                                            w_hit && byte_en[i]);
      end
      // Clear wins over everything on the same edge; register 0 is gated even
      // under bypass so a discarded write never leaks through this port.
      w_zero = clear || ((ZERO_REG != 0) && (read_addr == '0));
      w_next = w_zero ? '0 : w_merged;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_out <= '0;
         valid    <= 1'b0;
      end else begin
         valid <= rd_en;
         if (rd_en) begin
            data_out <= w_next;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/register_file_2r1w.sv
// ============================================================================
//  Module      : register_file_2r1w
//  Description : 2**ADDR_W x DATA_W register file, one byte-masked write port
//                and two independent registered read ports with write-first
//                bypass, synchronous bulk clear and optional zero register.
//  Ports       : clk, reset_n                  - clock, async active-low reset
//                clear                         - zero all registers
//                we, write_addr, byte_en,
//                data_in                       - write port
//                rd_en_a, read_addr_a,
//                data_out_a, valid_a           - read port A
//                rd_en_b, read_addr_b,
//                data_out_b, valid_b           - read port B
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_file_2r1w
   import register_file_2r1w_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 3,
   parameter int ZERO_REG = 0
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                clear,
   input  logic                we,
   input  logic [ADDR_W-1:0]   write_addr,
   input  logic [DATA_W/8-1:0] byte_en,
   input  logic [DATA_W-1:0]   data_in,
   input  logic                rd_en_a,
   input  logic [ADDR_W-1:0]   read_addr_a,
   output logic [DATA_W-1:0]   data_out_a,
   output logic                valid_a,
   input  logic                rd_en_b,
   input  logic [ADDR_W-1:0]   read_addr_b,
   output logic [DATA_W-1:0]   data_out_b,
   output logic                valid_b
);

   localparam int BE_W  = rf_be_w(DATA_W);
   localparam int DEPTH = rf_depth(ADDR_W);

   generate
      if ((DATA_W % 8) != 0) begin : g_data_w_check
         $error("register_file_2r1w: DATA_W must be a multiple of 8");
      end
   endgenerate

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] w_wr_word;
   logic              w_wr_en;

   always_comb begin
      w_wr_word = r_mem[write_addr];
      for (int i = 0; i < BE_W; i++) begin
         w_wr_word[8*i +: 8] = rf_merge_byte(r_mem[write_addr][8*i +: 8],
                                             data_in[8*i +: 8], byte_en[i]);
      end
      // An all-zero mask or a write to the hardwired zero register changes
      // nothing, so the storage enable is simply suppressed.
      w_wr_en = we && (byte_en != '0) &&
                !((ZERO_REG != 0) && (write_addr == '0));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (clear) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_wr_en) begin
         r_mem[write_addr] <= w_wr_word;
      end
   end

   register_file_2r1w_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_port_a (
      .clk        (clk),
      .reset_n    (reset_n),
      .clear      (clear),
      .rd_en      (rd_en_a),
      .read_addr  (read_addr_a),
      .rd_word    (r_mem[read_addr_a]),
      .we         (we),
      .write_addr (write_addr),
      .byte_en    (byte_en),
      .data_in    (data_in),
      .data_out   (data_out_a),
      .valid      (valid_a)
   );

   register_file_2r1w_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_port_b (
      .clk        (clk),
      .reset_n    (reset_n),
      .clear      (clear),
      .rd_en      (rd_en_b),
      .read_addr  (read_addr_b),
      .rd_word    (r_mem[read_addr_b]),
      .we         (we),
      .write_addr (write_addr),
      .byte_en    (byte_en),
      .data_in    (data_in),
      .data_out   (data_out_b),
      .valid      (valid_b)
   );

endmodule

`default_nettype wire
